// File: rtl/c1_cycle_sched_if.sv
// Bus-side signals of the C1 cycle scheduler: 68k strobes, zone decode and
// wait inputs in, DTACK/BERR/status out, plus the FSM state for observation.
interface c1_cycle_sched_if;
  logic       nAS;
  logic       nROM_ZONE;
  logic       nPORT_ZONE;
  logic       nCARD_ZONE;
  logic       nROMWAIT;
  logic       nPWAIT0;
  logic       nPWAIT1;
  logic       PDTACK;
  logic       nDTACK;
  logic       nBERR;
  logic       WAITING;
  logic       ZONE_ERR;
  logic [2:0] state;

  // Handshake: a cycle starts on the first edge nAS is sampled low after being
  // seen high; the scheduler answers with exactly one of nDTACK/nBERR (or none
  // on abort) and holds it until nAS is sampled high again.
  modport slave (
    input  nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nROMWAIT, nPWAIT0, nPWAIT1, PDTACK,
    output nDTACK, nBERR, WAITING, ZONE_ERR, state
  );

  modport master (
    output nAS, nROM_ZONE, nPORT_ZONE, nCARD_ZONE, nROMWAIT, nPWAIT0, nPWAIT1, PDTACK,
    input  nDTACK, nBERR, WAITING, ZONE_ERR, state
  );
endinterface

// File: rtl/c1_cycle_sched.sv
// Per-access 68k bus-cycle scheduler: counts wait states per decoded zone,
// optionally waits for cartridge PDTACK, then drives nDTACK or nBERR.
module c1_cycle_sched #(
  parameter int CARD_WAIT = 2,
  parameter int PDTACK_EN = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  c1_cycle_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    HOLD = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] count;
  logic [7:0] tcount;
  logic       hold;
  logic       armed;

  logic       rom, port, card;
  logic       multi;
  logic [3:0] w_start;
  logic       h_start;

  always_comb begin
    rom     = ~bus.nROM_ZONE;
    port    = ~bus.nPORT_ZONE;
    card    = ~bus.nCARD_ZONE;
    multi   = (rom & port) | (rom & card) | (port & card);
    w_start = 4'd0;
    if (rom)       w_start = {3'b000, ~bus.nROMWAIT};
    else if (port) w_start = {2'b00, ~bus.nPWAIT1, ~bus.nPWAIT0};
    else if (card) w_start = 4'(CARD_WAIT);
    h_start = ~rom & port & (PDTACK_EN != 0);
  end

  assign bus.state = state;

  // armed stays low after reset until nAS is seen high, so a cycle that was
  // in flight across reset can never be acknowledged.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state        <= IDLE;
      bus.nDTACK   <= 1'b1;
      bus.nBERR    <= 1'b1;
      bus.WAITING  <= 1'b0;
      bus.ZONE_ERR <= 1'b0;
      count        <= 4'd0;
      tcount       <= 8'd0;
      hold         <= 1'b0;
      armed        <= 1'b0;
    end else begin
      bus.ZONE_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.nAS) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed        <= 1'b0;
            hold         <= h_start;
            bus.ZONE_ERR <= multi;
            if (w_start != 4'd0) begin
              state       <= WAIT;
              count       <= w_start - 4'd1;
              bus.WAITING <= 1'b1;
            end else if (h_start && !bus.PDTACK) begin
              state       <= HOLD;
              tcount      <= 8'd0;
              bus.WAITING <= 1'b1;
            end else begin
              state      <= ACK;
              bus.nDTACK <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (bus.nAS) begin
            state       <= IDLE;
            bus.WAITING <= 1'b0;
            armed       <= 1'b1;
          end else if (count == 4'd0) begin
            if (hold && !bus.PDTACK) begin
              state  <= HOLD;
              tcount <= 8'd0;
            end else begin
              state       <= ACK;
              bus.WAITING <= 1'b0;
              bus.nDTACK  <= 1'b0;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        HOLD: begin
          if (bus.nAS) begin
            state       <= IDLE;
            bus.WAITING <= 1'b0;
            armed       <= 1'b1;
          end else if (bus.PDTACK) begin
            state       <= ACK;
            bus.WAITING <= 1'b0;
            bus.nDTACK  <= 1'b0;
          end else if (tcount == T_LAST) begin
            state       <= ERR;
            bus.WAITING <= 1'b0;
            bus.nBERR   <= 1'b0;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        ACK: begin
          if (bus.nAS) begin
            state      <= IDLE;
            bus.nDTACK <= 1'b1;
            armed      <= 1'b1;
          end
        end
        ERR: begin
          if (bus.nAS) begin
            state     <= IDLE;
            bus.nBERR <= 1'b1;
            armed     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1_cycle_sched.sv
// Directed bench for c1_cycle_sched with hand-computed edge timing.
module tb_c1_cycle_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  c1_cycle_sched_if bus();

  c1_cycle_sched #(
    .CARD_WAIT (2),
    .PDTACK_EN (1),
    .TIMEOUT   (4)
  ) dut (
    .CLK_68KCLK (clk),
    .RESET      (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.nAS        = 1'b1;
    bus.nROM_ZONE  = 1'b1;
    bus.nPORT_ZONE = 1'b1;
    bus.nCARD_ZONE = 1'b1;
    bus.nROMWAIT   = 1'b1;
    bus.nPWAIT0    = 1'b1;
    bus.nPWAIT1    = 1'b1;
    bus.PDTACK     = 1'b0;
  endtask

  task automatic release_cycle();
    idle_inputs();
    tick();
    chk("release_dtack", bus.nDTACK, 1'b1);
    chk("release_berr", bus.nBERR, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_dtack", bus.nDTACK, 1'b1);
    chk("rst_berr", bus.nBERR, 1'b1);
    chk("rst_waiting", bus.WAITING, 1'b0);
    chk("rst_zone_err", bus.ZONE_ERR, 1'b0);
    rst = 1'b0;
    tick();

    // ROM, no wait: ack right after the start edge, held until nAS rises
    bus.nROM_ZONE = 1'b0;
    bus.nAS       = 1'b0;
    tick();
    chk("rom0_e0_dtack", bus.nDTACK, 1'b0);
    chk("rom0_e0_waiting", bus.WAITING, 1'b0);
    chk("rom0_e0_zone_err", bus.ZONE_ERR, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rom0_hold_dtack", bus.nDTACK, 1'b0);
    end
    bus.nAS = 1'b1;
    tick();
    chk("rom0_e5_dtack", bus.nDTACK, 1'b1);
    idle_inputs();
    tick();

    // ROM, one wait state
    bus.nROM_ZONE = 1'b0;
    bus.nROMWAIT  = 1'b0;
    bus.nAS       = 1'b0;
    tick();
    chk("rom1_e0_dtack", bus.nDTACK, 1'b1);
    chk("rom1_e0_waiting", bus.WAITING, 1'b1);
    tick();
    chk("rom1_e1_dtack", bus.nDTACK, 1'b0);
    chk("rom1_e1_waiting", bus.WAITING, 1'b0);
    release_cycle();

    // PORT W=3 with PDTACK high; wait inputs changed mid-cycle must be ignored
    bus.nPORT_ZONE = 1'b0;
    bus.nPWAIT0    = 1'b0;
    bus.nPWAIT1    = 1'b0;
    bus.PDTACK     = 1'b1;
    bus.nAS        = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      tick();
      chk("port3_waiting", bus.WAITING, 1'b1);
      chk("port3_dtack_early", bus.nDTACK, 1'b1);
      if (i == 0) begin
        bus.nPWAIT0    = 1'b1;
        bus.nPWAIT1    = 1'b1;
        bus.nPORT_ZONE = 1'b1;
      end
    end
    tick();
    chk("port3_e3_dtack", bus.nDTACK, 1'b0);
    chk("port3_e3_waiting", bus.WAITING, 1'b0);
    release_cycle();

    // PORT W=0, PDTACK never comes: bus error after TIMEOUT edges in HOLD
    bus.nPORT_ZONE = 1'b0;
    bus.nAS        = 1'b0;
    tick();
    chk("to_e0_waiting", bus.WAITING, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_hold_waiting", bus.WAITING, 1'b1);
      chk("to_hold_berr", bus.nBERR, 1'b1);
    end
    tick();
    chk("to_e4_berr", bus.nBERR, 1'b0);
    chk("to_e4_dtack", bus.nDTACK, 1'b1);
    chk("to_e4_waiting", bus.WAITING, 1'b0);
    tick();
    tick();
    chk("to_held_berr", bus.nBERR, 1'b0);
    chk("to_held_dtack", bus.nDTACK, 1'b1);
    release_cycle();

    // PORT W=0, PDTACK raised before edge 2
    bus.nPORT_ZONE = 1'b0;
    bus.nAS        = 1'b0;
    tick();
    tick();
    chk("pd_e1_dtack", bus.nDTACK, 1'b1);
    bus.PDTACK = 1'b1;
    tick();
    chk("pd_e2_dtack", bus.nDTACK, 1'b0);
    chk("pd_e2_berr", bus.nBERR, 1'b1);
    release_cycle();

    // PORT W=2 then HOLD, PDTACK arrives before edge 4
    bus.nPORT_ZONE = 1'b0;
    bus.nPWAIT1    = 1'b0;
    bus.nAS        = 1'b0;
    tick();
    tick();
    tick();
    chk("wh_e2_waiting", bus.WAITING, 1'b1);
    chk("wh_e2_dtack", bus.nDTACK, 1'b1);
    tick();
    chk("wh_e3_dtack", bus.nDTACK, 1'b1);
    bus.PDTACK = 1'b1;
    tick();
    chk("wh_e4_dtack", bus.nDTACK, 1'b0);
    release_cycle();

    // CARD abort at edge 1, then a fresh cycle
    bus.nCARD_ZONE = 1'b0;
    bus.nAS        = 1'b0;
    tick();
    chk("card_e0_waiting", bus.WAITING, 1'b1);
    bus.nAS = 1'b1;
    tick();
    chk("card_abort_waiting", bus.WAITING, 1'b0);
    chk("card_abort_dtack", bus.nDTACK, 1'b1);
    chk("card_abort_berr", bus.nBERR, 1'b1);
    tick();
    chk("card_idle_dtack", bus.nDTACK, 1'b1);
    bus.nAS = 1'b0;
    tick();
    chk("card2_e0_dtack", bus.nDTACK, 1'b1);
    tick();
    chk("card2_e1_dtack", bus.nDTACK, 1'b1);
    tick();
    chk("card2_e2_dtack", bus.nDTACK, 1'b0);
    release_cycle();

    // Reset in the middle of a W=3 port cycle with nAS still low
    bus.nPORT_ZONE = 1'b0;
    bus.nPWAIT0    = 1'b0;
    bus.nPWAIT1    = 1'b0;
    bus.PDTACK     = 1'b1;
    bus.nAS        = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_waiting", bus.WAITING, 1'b0);
    chk("mrst_dtack", bus.nDTACK, 1'b1);
    chk("mrst_berr", bus.nBERR, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_noack_dtack", bus.nDTACK, 1'b1);
      chk("mrst_noack_waiting", bus.WAITING, 1'b0);
    end
    bus.nAS = 1'b1;
    tick();
    bus.nAS = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      tick();
      chk("mrst_new_waiting", bus.WAITING, 1'b1);
    end
    tick();
    chk("mrst_new_dtack", bus.nDTACK, 1'b0);
    release_cycle();

    // ROM and CARD strobes together: zone error pulse, ROM timing, one ack
    bus.nROM_ZONE  = 1'b0;
    bus.nCARD_ZONE = 1'b0;
    bus.nAS        = 1'b0;
    tick();
    chk("ze_e0_zone_err", bus.ZONE_ERR, 1'b1);
    chk("ze_e0_dtack", bus.nDTACK, 1'b0);
    tick();
    chk("ze_e1_zone_err", bus.ZONE_ERR, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      chk("ze_long_dtack", bus.nDTACK, 1'b0);
      chk("ze_long_berr", bus.nBERR, 1'b1);
      chk("ze_long_zone_err", bus.ZONE_ERR, 1'b0);
    end
    release_cycle();
    tick();
    chk("ze_after_dtack", bus.nDTACK, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
